// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART (TX shifter, RX deserializer + FIFO, status/ctrl, baud divisor); irq enabled by UART_MMIO_IRQ_EN
module uart_mmio #(
  parameter int CLK_HZ   = 27000000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [1:0] sel;
  logic [15:0] div, div_new;
  logic tx_busy, tx_load, tx_tick;
  state_t tx_st, tx_nx;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic rx_s1, rx_s2, rx_prev, rx_tick, rx_mid, rx_push, ferr_set;
  state_t rx_st, rx_nx;
  logic [15:0] rx_div, rx_cnt;
  logic [16:0] rx_half;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic [7:0] mem [RX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic rx_valid, rx_full, pop_req, do_pop, do_push, ovr_set, ovr, ferr;
  logic [1:0] ie;
  logic [31:0] rd;
  logic unused;
  assign unused = ^{addr[31:4], addr[1:0], wdata[31:16]};
  assign sel = addr[3:2];
  assign tx_busy = tx_st != IDLE;
  assign tx_load = write[0] && sel == 2'd0 && !tx_busy;
  assign pop_req = write[0] && sel == 2'd1 && wdata[0];
  assign div_new = {write[1] ? wdata[15:8] : div[15:8], write[0] ? wdata[7:0] : div[7:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= DIV_RST;
    else if (sel == 2'd3 && |write[1:0]) div <= div_new < 16'd4 ? 16'd4 : div_new;
  assign tx_tick = tx_cnt == tx_div;
  always_comb begin
    tx_nx = tx_st;
    unique case (tx_st)
      IDLE:  if (tx_load) tx_nx = START;
      START: if (tx_tick) tx_nx = DATA;
      DATA:  if (tx_tick && tx_bit == 3'd7) tx_nx = STOP;
      STOP:  if (tx_tick) tx_nx = IDLE;
    endcase
    uart_tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st  <= IDLE;
      tx_div <= '0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st <= tx_nx;
      if (tx_load) begin
        tx_div <= div;
        tx_sh  <= wdata[7:0];
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_busy) begin
        tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
        if (tx_tick && tx_st == DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_bit <= tx_bit + 3'd1;
        end
      end
    end
  assign rx_tick = rx_cnt == rx_div;
  assign rx_half = ({1'b0, rx_div} + 17'd1) >> 1;
  assign rx_mid  = {1'b0, rx_cnt} == rx_half - 17'd1;
  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      IDLE:  if (rx_prev && !rx_s2) rx_nx = START;
      START: if (rx_mid) rx_nx = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = STOP;
      STOP:  if (rx_tick) rx_nx = IDLE;
    endcase
    rx_push  = rx_st == STOP && rx_tick && rx_s2;
    ferr_set = rx_st == STOP && rx_tick && !rx_s2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_div  <= '0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_nx;
      if (rx_st == IDLE) begin
        rx_div <= div;
        rx_cnt <= '0;
        rx_bit <= '0;
      end else if (rx_st == START) rx_cnt <= rx_mid ? 16'd0 : rx_cnt + 16'd1;
      else begin
        rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
        if (rx_tick && rx_st == DATA) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
        end
      end
    end
  assign rx_valid = cnt != '0;
  assign rx_full  = cnt == CW'(RX_DEPTH);
  assign do_pop   = pop_req && rx_valid;
  assign do_push  = rx_push && (!rx_full || do_pop);
  assign ovr_set  = rx_push && rx_full && !do_pop;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= rx_sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      wp   <= wp + AW'(do_push);
      rp   <= rp + AW'(do_pop);
      cnt  <= cnt + CW'(do_push) - CW'(do_pop);
      ovr  <= ovr_set || (ovr && !(write[0] && sel == 2'd2 && wdata[3]));
      ferr <= ferr_set || (ferr && !(write[0] && sel == 2'd2 && wdata[4]));
    end
`ifdef UART_MMIO_IRQ_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ie  <= 2'b00;
      irq <= 1'b0;
    end else begin
      if (write[1] && sel == 2'd2) ie <= wdata[9:8];
      irq <= (ie[0] && (rx_valid || ovr || ferr)) || (ie[1] && !tx_busy);
    end
`else
  assign ie  = 2'b00;
  assign irq = 1'b0;
`endif
  always_comb
    rd = sel == 2'd1 ? {23'd0, rx_valid, mem[rp] & {8{rx_valid}}}
       : sel == 2'd2 ? {22'd0, ie, 3'd0, ferr, ovr, rx_full, rx_valid, tx_busy}
       : sel == 2'd3 ? {16'd0, div}
       : 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else rdata <= rd;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: randomized self-checking bench for uart_mmio against a queue-based reference model
module tb_uart_mmio;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, uart_rx = 1;
  logic [3:0] write = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata;
  logic uart_tx, irq;
  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  logic m_ovr = 0, m_ferr = 0, m_ie_tx = 0, m_ie_rx = 0;
  int m_div = 233;
  logic [31:0] r;

  uart_mmio #(.CLK_HZ(27000000), .BAUD(115200), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 0;
`ifdef UART_MMIO_IRQ_EN
    s[9] = m_ie_tx;
    s[8] = m_ie_rx;
`endif
    s[4] = m_ferr;
    s[3] = m_ovr;
    s[2] = q.size() == DEPTH;
    s[1] = q.size() != 0;
    return s;
  endfunction

  function automatic logic exp_irq();
`ifdef UART_MMIO_IRQ_EN
    return (m_ie_rx && (q.size() != 0 || m_ovr || m_ferr)) || m_ie_tx;
`else
    return 1'b0;
`endif
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    wdata = d;
    write = be;
    @(negedge clk);
    write = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    write = 0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (m_div + 1) @(negedge clk);
    end
    uart_rx = 1;
    repeat (4) @(negedge clk);
    if (!stop) m_ferr = 1;
    else if (q.size() == DEPTH) m_ovr = 1;
    else q.push_back(b);
  endtask

  task automatic pop();
    bus_write(2'd1, 32'd1, 4'b0001);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic inj);
    int p, len, idx;
    logic e;
    p = m_div + 1;
    len = 10 * p;
    bus_write(2'd0, {24'd0, b}, 4'b0001);
    for (int k = 0; k < len + 2; k++) begin
      idx = k / p;
      e = k >= len ? 1'b1 : idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : b[idx - 1];
      n_vec++;
      if (uart_tx !== e) begin
        n_err++;
        $display("FAIL tx_bit k=%0d data=%h: got %b expected %b", k, b, uart_tx, e);
      end
      if (k >= 1 && !(inj && (k == 41 || k == 61))) begin
        n_vec++;
        if (rdata[0] !== (k <= len)) begin
          n_err++;
          $display("FAIL tx_busy k=%0d: got %b expected %b", k, rdata[0], k <= len);
        end
      end
      if (k == 0) addr = 32'h8;
      if (inj && k == 40) begin addr = 32'h0; wdata = 32'hFF; write = 4'b0001; end
      if (inj && k == 60) begin addr = 32'hC; wdata = 32'h7; write = 4'b0011; end
      if (inj && (k == 41 || k == 61)) begin addr = 32'h8; write = 0; end
      @(negedge clk);
    end
    if (inj) m_div = 7;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (uart_tx !== 1'b1 || irq !== 1'b0 || rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got tx=%b irq=%b rdata=%h expected 1 0 0", uart_tx, irq, rdata);
    end
    rst = 0;
    bus_read(2'd3, r);
    n_vec++;
    if (r !== 32'd233) begin n_err++; $display("FAIL reset_div: got %0d expected 233", r); end
    bus_read(2'd2, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h expected 0", r); end
    bus_read(2'd1, r);
    n_vec++;
    if (r[31:8] !== 24'd0) begin n_err++; $display("FAIL reset_rxdata: got %h expected valid 0", r); end
  endtask

  task automatic test_div();
    logic [15:0] exp_v [4] = '{16'd4, 16'h0034, 16'h1234, 16'd4};
    logic [31:0] wd [4] = '{32'd2, 32'h34, 32'h1200, 32'h1};
    logic [3:0] be [4] = '{4'b0011, 4'b0001, 4'b0010, 4'b0001};
    bus_write(2'd3, 32'd4, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_write(2'd3, 32'h0, 4'b0010);
      bus_write(2'd3, wd[i], be[i]);
      bus_read(2'd3, r);
      n_vec++;
      if (r !== {16'd0, exp_v[i]}) begin
        n_err++;
        $display("FAIL div_write step %0d: got %h expected %h", i, r, exp_v[i]);
      end
    end
  endtask

  task automatic test_tx();
    int d;
    bus_write(2'd3, 32'd15, 4'b0011);
    m_div = 15;
    tx_frame(8'h55, 1'b1);
    tx_frame(8'hC3, 1'b0);
    repeat (3) begin
      d = $urandom_range(4, 10);
      bus_write(2'd3, d, 4'b0011);
      m_div = d;
      tx_frame(8'($urandom), 1'b0);
    end
  endtask

  task automatic test_rx();
    int d;
    bus_write(2'd3, 32'd15, 4'b0011);
    m_div = 15;
    send_rx(8'hA3, 1'b1);
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status()) begin n_err++; $display("FAIL rx_status: got %h expected %h", r, exp_status()); end
    repeat (2) begin
      bus_read(2'd1, r);
      n_vec++;
      if (r !== 32'h1A3) begin n_err++; $display("FAIL rx_head_stable: got %h expected 1a3", r); end
    end
    pop();
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status()) begin n_err++; $display("FAIL rx_after_pop: got %h expected %h", r, exp_status()); end
    d = $urandom_range(4, 20);
    bus_write(2'd3, d, 4'b0011);
    m_div = d;
    repeat (14) begin
      if ($urandom_range(0, 3) == 0) pop();
      else send_rx(8'($urandom), $urandom_range(0, 5) != 0);
      bus_read(2'd2, r);
      n_vec++;
      if (r !== exp_status()) begin n_err++; $display("FAIL rx_rand_status: got %h expected %h", r, exp_status()); end
      bus_read(2'd1, r);
      n_vec++;
      if (r[31:8] !== {23'd0, q.size() != 0} || (q.size() != 0 && r[7:0] !== q[0])) begin
        n_err++;
        $display("FAIL rx_rand_data: got %h expected valid=%0d head=%h", r, q.size() != 0, q.size() != 0 ? q[0] : 8'h00);
      end
    end
    while (q.size() != 0) pop();
    bus_write(2'd2, 32'h18, 4'b0001);
    m_ovr = 0;
    m_ferr = 0;
  endtask

  task automatic test_overrun();
    bus_write(2'd3, 32'd15, 4'b0011);
    m_div = 15;
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b1);
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status() || r[3:1] !== 3'b111) begin
      n_err++;
      $display("FAIL ovr_status: got %h expected %h", r, exp_status());
    end
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd1, r);
      n_vec++;
      if (r !== {23'd0, 1'b1, 8'(i)} || r[7:0] !== q[0]) begin
        n_err++;
        $display("FAIL ovr_drain %0d: got %h expected %h", i, r, {23'd0, 1'b1, 8'(i)});
      end
      pop();
    end
    bus_write(2'd2, 32'h08, 4'b0001);
    m_ovr = 0;
    bus_read(2'd2, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL ovr_clear: got %h expected 0", r); end
  endtask

  task automatic test_ferr_glitch();
    send_rx(8'h5A, 1'b1);
    send_rx(8'h77, 1'b0);
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status() || r[4] !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_status: got %h expected %h", r, exp_status());
    end
    bus_read(2'd1, r);
    n_vec++;
    if (r !== 32'h15A) begin n_err++; $display("FAIL ferr_fifo: got %h expected 15a", r); end
    uart_rx = 0;
    repeat (3) @(negedge clk);
    uart_rx = 1;
    repeat (40) @(negedge clk);
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status()) begin n_err++; $display("FAIL glitch_status: got %h expected %h", r, exp_status()); end
    bus_read(2'd1, r);
    n_vec++;
    if (r !== 32'h15A) begin n_err++; $display("FAIL glitch_fifo: got %h expected 15a", r); end
    bus_write(2'd2, 32'h10, 4'b0001);
    m_ferr = 0;
    pop();
    bus_read(2'd2, r);
    n_vec++;
    if (r !== 32'd0) begin n_err++; $display("FAIL ferr_clear: got %h expected 0", r); end
  endtask

  task automatic test_irq();
    logic e;
    bus_write(2'd2, 32'h100, 4'b0010);
    m_ie_rx = 1;
    @(negedge clk);
    n_vec++;
    if (irq !== exp_irq()) begin n_err++; $display("FAIL irq_idle: got %b expected %b", irq, exp_irq()); end
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status()) begin n_err++; $display("FAIL irq_ie_read: got %h expected %h", r, exp_status()); end
    send_rx(8'h42, 1'b1);
    n_vec++;
    if (irq !== exp_irq()) begin n_err++; $display("FAIL irq_rx: got %b expected %b", irq, exp_irq()); end
    pop();
    @(negedge clk);
    n_vec++;
    if (irq !== exp_irq()) begin n_err++; $display("FAIL irq_pop: got %b expected %b", irq, exp_irq()); end
    bus_write(2'd2, 32'h200, 4'b0010);
    m_ie_tx = 1;
    m_ie_rx = 0;
    @(negedge clk);
    n_vec++;
    if (irq !== exp_irq()) begin n_err++; $display("FAIL irq_tx_idle: got %b expected %b", irq, exp_irq()); end
    bus_write(2'd0, 32'h81, 4'b0001);
    @(negedge clk);
    e = 1'b0;
    n_vec++;
    if (irq !== e) begin n_err++; $display("FAIL irq_tx_busy: got %b expected %b", irq, e); end
    repeat (10 * (m_div + 1) + 2) @(negedge clk);
    n_vec++;
    if (irq !== exp_irq()) begin n_err++; $display("FAIL irq_tx_done: got %b expected %b", irq, exp_irq()); end
    bus_write(2'd2, 32'h0, 4'b0010);
    m_ie_tx = 0;
  endtask

  task automatic test_reset_midframe();
    send_rx(8'h3C, 1'b1);
    bus_write(2'd0, 32'h00, 4'b0001);
    repeat (20) @(negedge clk);
    n_vec++;
    if (uart_tx !== 1'b0) begin n_err++; $display("FAIL midframe_pre: got %b expected 0", uart_tx); end
    rst = 1;
    #1;
    n_vec++;
    if (uart_tx !== 1'b1 || rdata !== 32'd0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_async: got tx=%b rdata=%h irq=%b expected 1 0 0", uart_tx, rdata, irq);
    end
    @(negedge clk);
    rst = 0;
    q.delete();
    m_ovr = 0;
    m_ferr = 0;
    m_ie_tx = 0;
    m_ie_rx = 0;
    m_div = 233;
    bus_read(2'd2, r);
    n_vec++;
    if (r !== exp_status()) begin n_err++; $display("FAIL midframe_status: got %h expected %h", r, exp_status()); end
    bus_read(2'd3, r);
    n_vec++;
    if (r !== 32'd233) begin n_err++; $display("FAIL midframe_div: got %0d expected 233", r); end
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (uart_tx !== 1'b1) begin n_err++; $display("FAIL midframe_idle: got %b expected 1", uart_tx); end
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx();
    test_rx();
    test_overrun();
    test_ferr_glitch();
    test_irq();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral; one slave port of the SoC data-bus address multiplexer.
- Takes that slave's byte-write strobes, address and write data; returns read data.
- Drives the board TX pin and samples the RX pin.
- Provides a TX shifter, an RX deserializer with a small receive FIFO, status and control registers, and a programmable baud divisor.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz.
BAUD, 115200, default baud rate; sets the reset value of DIV.
RX_DEPTH, 8, RX FIFO entries; power of two, 2..64.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
write  input  4  byte write enables from the mux; nonzero means a write cycle
addr  input  32  byte address; only addr[3:2] decoded, other bits ignored
wdata  input  32  write data
rdata  output  32  registered read data
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous
irq  output  1  level interrupt request

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: a write with write[0]=1 while tx_busy=0 loads wdata[7:0] and starts a frame. A write while busy is dropped. Reads return 0.
  - 1 RXDATA: reads return {23'b0, rx_valid, fifo_head[7:0]} and are non-destructive. A write with write[0]=1 and wdata[0]=1 pops one entry; a pop when empty is ignored.
  - 2 STATUS: bit0 tx_busy, bit1 rx_valid, bit2 rx_full, bit3 overrun (sticky), bit4 frame_err (sticky). Writing 1 with write[0] clears bits 3/4 (W1C). Bits 9:8 are IE_TX/IE_RX, R/W via write[1].
  - 3 DIV: bits[15:0] R/W, clocks-per-bit minus 1. Byte lanes 0/1 are written independently. A resulting value <4 is stored as 4. Reset value is CLK_HZ/BAUD-1.
- Read latency: rdata is registered from addr on every clock, so data is valid the cycle after the address. This matches the mux's registered-select (BSRAM) mode. Reset value 0.
- Reset values: uart_tx=1, irq=0, FIFO empty, sticky bits 0, IE bits 0, both FSMs idle.
- Baud timing: DIV is latched into each FSM at frame start. A DIV write mid-frame affects only later frames. Bit period = DIV+1 clocks.
- TX FSM:
  - IDLE: a load moves to START.
  - START: uart_tx=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, then STOP.
  - STOP: uart_tx=1 for one bit period, then IDLE.
  - tx_busy=1 in every state except IDLE. The first start bit appears the cycle after the write.
- RX path: uart_rx passes through a 2-flop synchronizer (preset to 1 on reset). RX FSM:
  - IDLE: waits for a synchronized falling edge.
  - START: waits (DIV+1)/2 clocks. If the line is high, it was a glitch: return to IDLE with nothing pushed. If low, go to DATA.
  - DATA: samples 8 bits at mid-bit, spaced DIV+1 clocks apart.
  - STOP: samples once. A 1 pushes the byte. A 0 sets frame_err and discards the byte. Either way return to IDLE.
- FIFO boundaries:
  - Push when full with no pop: byte dropped, overrun set.
  - Push and pop in the same cycle: both occur, including when full (count unchanged, no overrun).
  - Head data is stable while not popped.
  - Pointers wrap modulo RX_DEPTH. Count width is $clog2(RX_DEPTH)+1.
- Sticky set vs. clear: if a set event and a W1C occur in the same cycle, the set wins.
- Reset asserted mid-frame aborts both FSMs immediately, drives uart_tx=1 and empties the FIFO.

Optional Feature:
- Macro UART_MMIO_IRQ_EN.
  - Defined: irq is registered, irq = (IE_RX & rx_valid) | (IE_TX & ~tx_busy) | (IE_RX & (overrun|frame_err)).
  - Undefined: irq is tied 0, IE bits read 0 and ignore writes. All other behaviour is identical.

Test Plan:
- Reset then read DIV at addr 0xC -> rdata=233 (27 MHz/115200-1) one cycle later. Read STATUS -> 0.
- Write DIV=15, write TXDATA=0x55 -> uart_tx low 16 clks, then 1,0,1,0,1,0,1,0 at 16 clks each, then high 16 clks. tx_busy=1 for 160 clks. A second TXDATA write during the frame is dropped.
- DIV=15, drive RX frame 0xA3 -> STATUS.rx_valid=1. RXDATA reads 0x1A3 twice unchanged. Write RXDATA wdata=1 -> rx_valid=0.
- Send 9 bytes 0x01..0x09 without popping (RX_DEPTH=8) -> rx_full=1, overrun=1, head=0x01. 8 pops return 0x01..0x08. Write STATUS 0x08 -> overrun cleared.
- RX frame with stop bit 0 -> frame_err=1, FIFO unchanged. A 3-clock low glitch on uart_rx -> no push, no error.
- With UART_MMIO_IRQ_EN, set IE_RX, receive 0x42 -> irq=1 the cycle after the push. Pop -> irq=0. Without the macro, irq stays 0 throughout.
